divider_ctrl: RTL and testbench
===============================

DIVIDER_CTRL -- requirements
Module: divider_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand width and the iteration count.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 SHALL have port divisor, input, WIDTH bits: checked for zero on the edge start is accepted.
REQ-006 SHALL have port rem_sign, input, 1 bit: sign bit of the datapath remainder (R MSB).
REQ-007 SHALL have outputs load, shift_en, sub_en, add_en, final_add, count_en, 1 bit each: datapath control strobes.
REQ-008 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted through the DONE cycle.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse meaning the result is valid.
REQ-010 SHALL have port div_err, output, 1 bit: divide-by-zero flag, held until the next accepted start.

Function
REQ-011 SHALL implement Moore FSM states IDLE, LOAD, SHIFT, OP, CORRECT, DONE; all strobes are decoded from state plus rem_sign only.
REQ-012 SHALL, in IDLE, move to LOAD when start=1 and divisor!=0, and clear div_err.
REQ-013 SHALL, in IDLE, move directly to DONE when start=1 and divisor==0, and set div_err=1; load is never asserted in this case.
REQ-014 SHALL assert load=1 in LOAD, clear the internal iteration counter to 0, and move to SHIFT.
REQ-015 SHALL assert shift_en=1 in SHIFT and move to OP.
REQ-016 SHALL, in OP, assert sub_en=1 if rem_sign=0, else add_en=1, and assert count_en=1 in the same cycle.
REQ-017 SHALL, in OP, increment the iteration counter and move to SHIFT if counter<WIDTH-1, else to CORRECT.
REQ-018 SHALL assert final_add=1 in CORRECT only if rem_sign=1, then move to DONE.
REQ-019 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-020 SHALL assert at most one of load, shift_en, sub_en, add_en, final_add in any cycle.
REQ-021 SHALL time a non-zero division with start accepted at edge E0 as: LOAD in cycle 1, SHIFT/OP alternating in cycles 2-17, CORRECT in cycle 18, done in cycle 19 (WIDTH=8; generally 2*WIDTH+3).
REQ-022 SHALL time a zero-divisor division with start accepted at edge E0 as: done and div_err=1 in cycle 1.
REQ-023 SHALL ignore start while busy=1, with no restart and no state change.
REQ-024 SHALL, when start=1 in the DONE cycle, ignore it; a new start is accepted no earlier than the following IDLE cycle.
REQ-025 SHALL size the iteration counter to $clog2(WIDTH) bits minimum and never wrap inside an operation.
REQ-026 SHALL hold all strobe outputs at 0 in IDLE.

Reset
REQ-027 SHALL, on reset=1 at any time including mid-operation, immediately force the state to IDLE, the counter to 0, and busy, done, div_err and all strobes to 0, without waiting for a clock.
REQ-028 SHALL, after reset deasserts, accept start on the first rising edge.

Verification
REQ-029 SHALL pass: start with dividend=100, divisor=7 into a connected 8-bit divider -> load in cycle 1, 8 shift_en and 8 count_en pulses, done in cycle 19, quotient=14, remainder=2, div_err=0.
REQ-030 SHALL pass: start with divisor=0 -> done and div_err=1 in cycle 1, no load/shift_en/sub_en/add_en/count_en ever high, busy high 1 cycle.
REQ-031 SHALL pass: rem_sign forced 1 at CORRECT -> final_add=1 in cycle 18; rem_sign forced 0 -> final_add stays 0, done still in cycle 19.
REQ-032 SHALL pass: start pulsed again in cycles 5 and 19 -> ignored, single done in cycle 19, next start accepted only from IDLE.
REQ-033 SHALL pass: reset asserted asynchronously in cycle 9 -> outputs 0 before the next clock edge, FSM in IDLE, a fresh 100/7 start completes correctly in 19 cycles.
REQ-034 SHALL pass: random divisor 1-255 and rem_sign sequences -> one-hot strobe check holds every cycle, sub_en/add_en choice matches rem_sign in every OP cycle.

Source files
------------

// File: rtl/divider_ctrl.sv
// Control FSM for a WIDTH-bit non-restoring divider: sequences load, shift,
// add/subtract and final correction strobes, and flags divide-by-zero.
module divider_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] divisor,
  input  logic             rem_sign,
  output logic             load,
  output logic             shift_en,
  output logic             sub_en,
  output logic             add_en,
  output logic             final_add,
  output logic             count_en,
  output logic             busy,
  output logic             done,
  output logic             div_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, OP, CORRECT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          div_zero;

  always_comb begin
    accept   = (state == IDLE) && start;
    div_zero = (divisor == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter holds at LAST on the final OP so it never wraps mid-operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      div_err <= 1'b0;
    end else begin
      if (accept) begin
        div_err <= div_zero;
      end
      if (state == LOAD) begin
        cnt <= '0;
      end else if ((state == OP) && (cnt != LAST)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    sub_en    = 1'b0;
    add_en    = 1'b0;
    final_add = 1'b0;
    count_en  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = div_zero ? DONE : LOAD;
        end
      end
      LOAD: begin
        load      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shift_en  = 1'b1;
        state_nxt = OP;
      end
      OP: begin
        sub_en    = ~rem_sign;
        add_en    = rem_sign;
        count_en  = 1'b1;
        state_nxt = (cnt == LAST) ? CORRECT : SHIFT;
      end
      CORRECT: begin
        final_add = rem_sign;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// Bench for divider_ctrl: drives a behavioural non-restoring datapath from the
// strobes and checks a cycle-indexed schedule plus quotient/remainder.
module tb_divider_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] divisor;
  logic [W-1:0] dividend;
  logic         rem_sign;
  logic         load, shift_en, sub_en, add_en, final_add, count_en;
  logic         busy, done, div_err;

  logic         force_en;
  logic         force_val;
  logic [W+1:0] a_reg, m_reg, a_op;
  logic [W-1:0] q_reg;
  logic [8:0]   obs;

  int total = 0;
  int bad   = 0;

  divider_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .divisor   (divisor),
    .rem_sign  (rem_sign),
    .load      (load),
    .shift_en  (shift_en),
    .sub_en    (sub_en),
    .add_en    (add_en),
    .final_add (final_add),
    .count_en  (count_en),
    .busy      (busy),
    .done      (done),
    .div_err   (div_err)
  );

  always #5 clk = ~clk;

  // Datapath model: A is two bits wider than the operands so 2*A never overflows.
  always_comb begin
    a_op     = add_en ? (a_reg + m_reg) : (a_reg - m_reg);
    rem_sign = force_en ? force_val : a_reg[W+1];
    obs      = {load, shift_en, sub_en, add_en, final_add, count_en, busy, done, div_err};
  end

  always_ff @(posedge clk) begin
    if (load) begin
      a_reg <= '0;
      q_reg <= dividend;
      m_reg <= {2'b00, divisor};
    end else if (shift_en) begin
      {a_reg, q_reg} <= {a_reg[W:0], q_reg, 1'b0};
    end else if (sub_en || add_en) begin
      a_reg <= a_op;
      if (count_en) q_reg[0] <= ~a_op[W+1];
    end else if (final_add) begin
      a_reg <= a_reg + m_reg;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Expected {load,shift,sub,add,final,count,busy,done,div_err} for cycle cyc after acceptance.
  function automatic logic [8:0] sched(input int cyc, input int len, input bit err, input bit rs);
    logic [8:0] e;
    e = '0;
    e[0] = err;
    if (cyc <= len) e[2] = 1'b1;
    if (cyc == len) e[1] = 1'b1;
    if (!err) begin
      if (cyc == 1) e[8] = 1'b1;
      else if (cyc >= 2 && cyc <= 2*W+1) begin
        if (cyc % 2 == 0) e[7] = 1'b1;
        else begin
          e[6] = ~rs;
          e[5] = rs;
          e[3] = 1'b1;
        end
      end else if (cyc == 2*W+2) e[4] = rs;
    end
    return e;
  endfunction

  // fmode: 0 real rem_sign, 1 force 1 at CORRECT, 2 force 0 at CORRECT, 3 random every cycle.
  task automatic run_div(input logic [W-1:0] dd, input logic [W-1:0] dv, input int fmode,
                         input bit extra, input bit chk_res);
    int len;
    int n_sh;
    int n_cnt;
    bit err;
    err   = (dv == '0);
    len   = err ? 1 : 2*W+3;
    n_sh  = 0;
    n_cnt = 0;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    for (int cyc = 1; cyc <= len + 1; cyc++) begin
      @(posedge clk);
      #2;
      start    = 1'b0;
      force_en = 1'b0;
      if ((fmode == 1 || fmode == 2) && cyc == 2*W+2) begin
        force_en  = 1'b1;
        force_val = (fmode == 1);
      end else if (fmode == 3) begin
        force_en  = 1'b1;
        force_val = 1'($urandom);
      end
      #1;
      chk($sformatf("sched dd=%0d dv=%0d cyc=%0d", dd, dv, cyc), 32'(obs),
          32'(sched(cyc, len, err, rem_sign)));
      chk($sformatf("onehot cyc=%0d", cyc), 32'($countones(obs[8:4]) <= 1), 32'd1);
      n_sh  += int'(shift_en);
      n_cnt += int'(count_en);
      if (extra && (cyc == 5 || cyc == len)) start = 1'b1;
    end
    force_en = 1'b0;
    start    = 1'b0;
    chk($sformatf("shift_pulses dv=%0d", dv), 32'(n_sh), err ? 32'd0 : 32'(W));
    chk($sformatf("count_pulses dv=%0d", dv), 32'(n_cnt), err ? 32'd0 : 32'(W));
    if (chk_res && !err && fmode == 0) begin
      chk($sformatf("quotient %0d/%0d", dd, dv), 32'(q_reg), 32'(dd / dv));
      chk($sformatf("remainder %0d/%0d", dd, dv), 32'(a_reg[W-1:0]), 32'(dd % dv));
    end
  endtask

  typedef struct {
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    int           fmode;
    bit           extra;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    divisor   = '0;
    dividend  = '0;
    force_en  = 1'b0;
    force_val = 1'b0;

    vecs.push_back('{8'd100, 8'd7,   0, 1'b0});
    vecs.push_back('{8'd255, 8'd1,   0, 1'b0});
    vecs.push_back('{8'd0,   8'd5,   0, 1'b0});
    vecs.push_back('{8'd255, 8'd255, 0, 1'b0});
    vecs.push_back('{8'd7,   8'd100, 0, 1'b0});
    vecs.push_back('{8'd100, 8'd0,   0, 1'b0});
    vecs.push_back('{8'd200, 8'd3,   1, 1'b0});
    vecs.push_back('{8'd200, 8'd3,   2, 1'b0});
    vecs.push_back('{8'd100, 8'd7,   0, 1'b1});
    vecs.push_back('{8'd9,   8'd0,   0, 1'b1});
    vecs.push_back('{8'd128, 8'd200, 0, 1'b0});

    repeat (2) @(posedge clk);
    #3;
    chk("reset_outputs", 32'(obs), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_div(vecs[i].dd, vecs[i].dv, vecs[i].fmode, vecs[i].extra, 1'b1);

    for (int i = 0; i < 20; i++) begin
      run_div(8'($urandom), 8'($urandom_range(1, 255)), (i % 2 == 0) ? 0 : 3, 1'b0, 1'b1);
    end

    // Async reset clears a held div_err without a clock edge.
    run_div(8'd5, 8'd0, 0, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    chk("reset_clears_div_err", 32'(obs), 32'd0);
    #1;
    reset = 1'b0;

    // Async reset in cycle 9 of a live division.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    chk("busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midop_reset_outputs", 32'(obs), 32'd0);
    @(posedge clk);
    #3;
    chk("held_in_reset", 32'(obs), 32'd0);
    reset = 1'b0;
    run_div(8'd100, 8'd7, 0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
